// File: rtl/wb_cmd_master.sv
// Command/response front end that turns one command at a time into a Wishbone
// classic bus cycle, with a bounded wait for the slave acknowledge.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic        accept;
    logic        timeout_hit;
    logic        rsp_take;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        accept      = (state == IDLE) && cmd_valid;
        // An acknowledge in the final allowed cycle takes priority over the timeout.
        timeout_hit = (state == BUS) && !wbm_ack_i && (wait_cnt == WAIT_LAST);
        rsp_take    = (state == RESP) && rsp_ready;
        next_state  = state;
        case (state)
            IDLE:    if (cmd_valid) next_state = BUS;
            BUS:     if (wbm_ack_i || timeout_hit) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
        end else if (accept) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wait_cnt  <= '0;
        end else if (state == BUS) begin
            if (wbm_ack_i) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
            end else if (timeout_hit) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_dat   <= ERR_DATA;
            end else begin
                wait_cnt  <= wait_cnt + 16'd1;
            end
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master against a transaction-level reference model.
module tb_wb_cmd_master;

    localparam int unsigned T   = 4;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by bus_txn; every test compares them itself.
    int          obs_cyc;
    logic        obs_fields_ok, obs_seen, obs_err, obs_stable_ok, obs_post_ok, obs_ready_ok;
    logic [31:0] obs_dat;

    wb_cmd_master #(.TIMEOUT(T), .ERR_DATA(ERR)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference expectations derived from the transaction rules: the slave acks in
    // BUS cycle ack_at (0 = never); the cycle lasts until ack or T cycles elapse.
    function automatic int exp_cycles(input int ack_at);
        return (ack_at >= 1 && ack_at <= int'(T)) ? ack_at : int'(T);
    endfunction

    function automatic logic exp_error(input int ack_at);
        return !(ack_at >= 1 && ack_at <= int'(T));
    endfunction

    function automatic logic [31:0] exp_data(input int ack_at, input logic we, input logic [31:0] rdat);
        if (exp_error(ack_at)) return ERR;
        return we ? 32'h0 : rdat;
    endfunction

    task automatic bus_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                           input int hold);
        int w;
        obs_cyc = 0; obs_fields_ok = 1'b1; obs_seen = 1'b0; obs_stable_ok = 1'b1;
        obs_post_ok = 1'b1; obs_ready_ok = 1'b1;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        obs_ready_ok = cmd_ready;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        wbm_ack_i = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_sel = 4'($urandom);
        while (wbm_cyc_o && obs_cyc < int'(T) + 3) begin
            obs_cyc++;
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
                wbm_dat_o !== dat || wbm_sel_o !== sel)
                obs_fields_ok = 1'b0;
            wbm_ack_i = (obs_cyc == ack_at);
            wbm_dat_i = wbm_ack_i ? rdat : $urandom;
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        obs_seen = rsp_valid; obs_dat = rsp_dat; obs_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_adr = $urandom;
            wbm_ack_i = 1'($urandom); wbm_dat_i = $urandom;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== obs_dat || rsp_err !== obs_err ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
                wbm_we_o !== 1'b0)
                obs_stable_ok = 1'b0;
        end
        cmd_valid = 1'b0; wbm_ack_i = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) obs_post_ok = 1'b0;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err});
        end
        n_checks++;
        if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_data: adr=%h dat=%h sel=%h rsp_dat=%h want all zero",
                     wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_idle_ack();
        logic bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
            @(negedge clk);
            if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
        end
        wbm_ack_i = 1'b0;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack: state disturbed got bad=%b want 0", bad);
        end
    endtask

    task automatic test_write();
        bus_txn(1'b1, 32'h3000_0004, 32'h0000_0055, 4'hF, 2, 32'hDEAD_BEEF, 0);
        n_checks++;
        if (obs_cyc !== 2 || obs_fields_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL write_bus: cycles=%0d fields_ok=%b want 2/1", obs_cyc, obs_fields_ok);
        end
        n_checks++;
        if (obs_seen !== 1'b1 || obs_err !== 1'b0 || obs_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL write_rsp: valid=%b err=%b dat=%h want 1/0/00000000", obs_seen, obs_err, obs_dat);
        end
        n_checks++;
        if (obs_post_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL write_handshake: got %b want 1", obs_post_ok);
        end
    endtask

    task automatic test_read();
        bus_txn(1'b0, 32'h3000_0000, $urandom, 4'hF, 1, 32'hA5A5_1234, 0);
        n_checks++;
        if (obs_cyc !== 1 || obs_fields_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL read_bus: cycles=%0d fields_ok=%b want 1/1", obs_cyc, obs_fields_ok);
        end
        n_checks++;
        if (obs_seen !== 1'b1 || obs_err !== 1'b0 || obs_dat !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL read_rsp: valid=%b err=%b dat=%h want 1/0/a5a51234", obs_seen, obs_err, obs_dat);
        end
    endtask

    task automatic test_timeout();
        bus_txn(1'b0, $urandom, $urandom, 4'($urandom), 0, 32'h0, 0);
        n_checks++;
        if (obs_cyc !== int'(T)) begin
            n_fail++;
            $display("FAIL timeout_len: cycles=%0d want %0d", obs_cyc, T);
        end
        n_checks++;
        if (obs_seen !== 1'b1 || obs_err !== 1'b1 || obs_dat !== ERR) begin
            n_fail++;
            $display("FAIL timeout_rsp: valid=%b err=%b dat=%h want 1/1/%h", obs_seen, obs_err, obs_dat, ERR);
        end
    endtask

    task automatic test_ack_at_limit();
        logic [31:0] rd = $urandom;
        bus_txn(1'b0, $urandom, $urandom, 4'hF, int'(T), rd, 0);
        n_checks++;
        if (obs_cyc !== int'(T) || obs_err !== 1'b0 || obs_dat !== rd) begin
            n_fail++;
            $display("FAIL ack_limit: cycles=%0d err=%b dat=%h want %0d/0/%h", obs_cyc, obs_err, obs_dat, T, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd = $urandom;
        bus_txn(1'b0, $urandom, $urandom, 4'hF, 1, rd, 5);
        n_checks++;
        if (obs_stable_ok !== 1'b1 || obs_dat !== rd) begin
            n_fail++;
            $display("FAIL backpressure_hold: stable=%b dat=%h want 1/%h", obs_stable_ok, obs_dat, rd);
        end
        n_checks++;
        if (obs_post_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got %b want 1", obs_post_ok);
        end
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (wbm_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_accept: cyc=%b want 1", wbm_cyc_o);
        end
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          acc[$];
        logic [31:0] last_dat = '0;
        logic        rsp_bad = 1'b0;
        logic        gap_bad = 1'b0;
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && (rsp_dat !== last_dat || rsp_err !== 1'b0)) rsp_bad = 1'b1;
            if (cmd_ready === 1'b1) acc.push_back(i);
            cmd_adr = $urandom;
            wbm_ack_i = wbm_cyc_o;
            if (wbm_cyc_o === 1'b1) begin
                wbm_dat_i = $urandom;
                last_dat  = wbm_dat_i;
            end
        end
        cmd_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            wbm_ack_i = wbm_cyc_o;
        end
        wbm_ack_i = 1'b0; rsp_ready = 1'b0;
        for (int k = 1; k < acc.size(); k++)
            if (acc[k] - acc[k-1] != 3) gap_bad = 1'b1;
        n_checks++;
        if (acc.size() !== 10 || gap_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_spacing: accepts=%0d gap_bad=%b want 10/0", acc.size(), gap_bad);
        end
        n_checks++;
        if (rsp_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_data: rsp_bad=%b want 0", rsp_bad);
        end
    endtask

    task automatic test_reset_mid_bus();
        logic bad = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wbm_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midbus_pre: cyc=%b want 1", wbm_cyc_o);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid} !== 4'b0 || {wbm_adr_o, wbm_sel_o} !== 36'b0) begin
            n_fail++;
            $display("FAIL midbus_reset: ctrl=%b adr=%h sel=%h want 0000/0/0",
                     {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid}, wbm_adr_o, wbm_sel_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midbus_ready: got %b want 1", cmd_ready);
        end
        for (int i = 0; i < 6; i++) begin
            wbm_ack_i = 1'($urandom);
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) bad = 1'b1;
        end
        wbm_ack_i = 1'b0;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midbus_no_rsp: bad=%b want 0", bad);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic        we   = 1'($urandom);
            logic [31:0] adr  = $urandom;
            logic [31:0] dat  = $urandom;
            logic [3:0]  sel  = 4'($urandom);
            logic [31:0] rd   = $urandom;
            int          ack  = int'($urandom_range(1, T + 2));
            int          hold = int'($urandom_range(0, 3));
            bus_txn(we, adr, dat, sel, ack, rd, hold);
            n_checks++;
            if (obs_cyc !== exp_cycles(ack) || obs_fields_ok !== 1'b1 || obs_ready_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_bus[%0d]: cycles=%0d fields_ok=%b ready=%b want %0d/1/1",
                         n, obs_cyc, obs_fields_ok, obs_ready_ok, exp_cycles(ack));
            end
            n_checks++;
            if (obs_seen !== 1'b1 || obs_err !== exp_error(ack) || obs_dat !== exp_data(ack, we, rd)) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: valid=%b err=%b dat=%h want 1/%b/%h",
                         n, obs_seen, obs_err, obs_dat, exp_error(ack), exp_data(ack, we, rd));
            end
            n_checks++;
            if (obs_stable_ok !== 1'b1 || obs_post_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_hold[%0d]: stable=%b post=%b want 1/1", n, obs_stable_ok, obs_post_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_ack();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_limit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a bus cycle waits for wbm_ack_i (legal range 1..65535).
REQ-002 The block SHALL have parameter ERR_DATA, default 32'hFFFF_FFFF, meaning the rsp_dat value returned on timeout.
REQ-003 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-007 cmd_we  in  1  1=write, 0=read.
REQ-008 cmd_adr  in  32  byte address.
REQ-009 cmd_dat  in  32  write data.
REQ-010 cmd_sel  in  4  byte lane selects.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
REQ-013 rsp_dat  out  32  read data, or ERR_DATA on error.
REQ-014 rsp_err  out  1  1=timeout, no ack.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-016 wbm_adr_o  out  32; wbm_dat_o  out  32; wbm_sel_o  out  4  Wishbone address/data/selects.
REQ-017 wbm_ack_i  in  1; wbm_dat_i  in  32  slave acknowledge and read data.

Function
REQ-018 The FSM SHALL have states IDLE, BUS, RESP; cmd_ready SHALL be 1 only in IDLE (one outstanding command max).
REQ-019 IDLE -> BUS on cmd_valid&&cmd_ready; cmd_we/adr/dat/sel SHALL be registered at acceptance and held constant on wbm_* until the bus cycle ends.
REQ-020 wbm_cyc_o and wbm_stb_o SHALL be registered, both 1 throughout BUS and 0 otherwise, asserting the cycle after acceptance.
REQ-021 In BUS, wbm_ack_i=1 at a rising edge SHALL end the cycle: cyc/stb 0 and rsp_valid 1 on the next cycle, state RESP.
REQ-022 On ack, rsp_err SHALL be 0; rsp_dat SHALL capture wbm_dat_i for reads and be 32'h0 for writes.
REQ-023 A 16-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-024 If no ack and counter==TIMEOUT-1, BUS -> RESP with rsp_err=1, rsp_dat=ERR_DATA; cyc/stb SHALL thus be high exactly TIMEOUT cycles.
REQ-025 Ack in the same cycle as the timeout condition SHALL win: normal response, rsp_err=0.
REQ-026 wbm_ack_i outside BUS SHALL be ignored (no state or output change).
REQ-027 In RESP, rsp_valid/rsp_dat/rsp_err SHALL hold stable until rsp_valid&&rsp_ready, then -> IDLE with rsp_valid 0 next cycle.
REQ-028 cmd_ready SHALL become 1 the cycle after the response handshake; minimum command-to-command spacing with zero-wait slave and rsp_ready=1 is 3 cycles.
REQ-029 wbm_we_o SHALL be 0 outside BUS.

Reset
REQ-030 wb_rst_i=1 at a rising edge SHALL force IDLE, cyc/stb/we 0, rsp_valid 0, rsp_err 0, rsp_dat 0, wbm_adr_o/dat_o/sel_o 0, counter 0, regardless of state.
REQ-031 Reset during BUS SHALL drop cyc/stb the next cycle with no response generated; cmd_ready SHALL be 1 the first cycle after reset deasserts.

Verification
REQ-032 Write: cmd we=1 adr=0x3000_0004 dat=0x0000_0055 sel=0xF, slave acks 2nd BUS cycle -> wbm_* match for 2 cycles, rsp_valid=1 rsp_err=0 rsp_dat=0.
REQ-033 Read: cmd we=0 adr=0x3000_0000, slave acks 1st cycle with 0xA5A5_1234 -> rsp_dat=0xA5A5_1234, rsp_err=0, cyc high 1 cycle.
REQ-034 Timeout: TIMEOUT=4, slave never acks -> cyc/stb high exactly 4 cycles, rsp_err=1, rsp_dat=0xFFFF_FFFF.
REQ-035 Ack on 4th cycle with TIMEOUT=4 -> rsp_err=0, read data returned.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, new cmd_valid not accepted; accepted cycle after handshake.
REQ-037 Reset asserted mid-BUS -> cyc/stb 0 next cycle, rsp_valid never asserts, cmd_ready=1 after release.
